// File: rtl/pdm_decimator_pkg.sv
// ============================================================================
// Module   : pdm_decimator_pkg
// Purpose  : Shared CIC constants and helpers for the PDM decimator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_decimator_pkg;

  localparam int CIC_ORDER = 2;

  // Register growth of an order-N CIC plus one guard bit so R^N itself fits.
  function automatic int cic_width(input int log2_decim);
    return CIC_ORDER * log2_decim + 1;
  endfunction

  // Clamp the comb result to 2^(2*L)-1, then drop the low bits beyond out_w.
  function automatic logic [31:0] sat_shift(input logic [31:0] value,
                                            input int          log2_decim,
                                            input int          out_w);
    logic [31:0] max_v;
    logic [31:0] clamped;
    max_v   = (32'd1 << (CIC_ORDER * log2_decim)) - 32'd1;
    clamped = (value > max_v) ? max_v : value;
    return clamped >> (CIC_ORDER * log2_decim - out_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_decimator_bit_sync_2ff.sv
// ============================================================================
// Module   : bit_sync_2ff
// Purpose  : Two-flop synchronizer for an asynchronous single-bit input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync_2ff
  import pdm_decimator_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pdm_decimator.sv
// ============================================================================
// Module   : pdm_decimator
// Purpose  : 2nd-order CIC decimator turning a strobed PDM bit stream into
//            unsigned PCM samples on a valid/ready port.
//            Define PDM_DECIM_SYNC_EN to pass pdm_in through a 2-flop sync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_decimator
  import pdm_decimator_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 8,
  parameter int LOG2_DECIM   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    pdm_in,
  output logic [OUTPUT_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun
);

  localparam int W = cic_width(LOG2_DECIM);

  logic                    pdm_bit;
  logic [W-1:0]            i1_q, i1_d;
  logic [W-1:0]            i2_q, i2_d;
  logic [W-1:0]            d1_q, d2_q;
  logic [W-1:0]            c1_d, c2_d, c2_q;
  logic [LOG2_DECIM-1:0]   phase_q;
  logic                    arm_q, arm_d;
  logic                    comb_vld_q;
  logic [OUTPUT_WIDTH-1:0] y_d;
  logic [OUTPUT_WIDTH-1:0] sample_out_q;
  logic                    sample_valid_q;
  logic                    overrun_q;

`ifdef PDM_DECIM_SYNC_EN
  bit_sync_2ff u_pdm_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pdm_in),
    .q_o (pdm_bit)
  );
`else
  assign pdm_bit = pdm_in;
`endif

  assign i1_d  = i1_q + {{(W-1){1'b0}}, pdm_bit};
  assign i2_d  = i2_q + i1_d;
  assign arm_d = clk_en && (phase_q == {LOG2_DECIM{1'b1}});

  // Modular subtraction recovers the exact comb value since it never exceeds R^2.
  assign c1_d = i2_q - d1_q;
  assign c2_d = c1_d - d2_q;
  assign y_d  = OUTPUT_WIDTH'(sat_shift(32'(c2_q), LOG2_DECIM, OUTPUT_WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1_q           <= '0;
      i2_q           <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      c2_q           <= '0;
      phase_q        <= '0;
      arm_q          <= 1'b0;
      comb_vld_q     <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (clk_en) begin
        i1_q    <= i1_d;
        i2_q    <= i2_d;
        phase_q <= phase_q + LOG2_DECIM'(1);
      end
      arm_q      <= arm_d;
      comb_vld_q <= arm_q;
      if (arm_q) begin
        d1_q <= i2_q;
        d2_q <= c1_d;
        c2_q <= c2_d;
      end
      // A fresh sample wins over acceptance; it only overruns if unaccepted.
      if (comb_vld_q) begin
        sample_out_q   <= y_d;
        sample_valid_q <= 1'b1;
        if (sample_valid_q && !sample_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (sample_valid_q && sample_ready) begin
        sample_valid_q <= 1'b0;
      end
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_decimator.sv
// ============================================================================
// Module   : tb_pdm_decimator
// Purpose  : Directed self-checking bench for pdm_decimator (R=16, 8-bit out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_decimator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b0;
  logic       pdm_in = 1'b0;
  logic       sample_ready = 1'b0;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;

  logic       obs_v [3];
  logic [7:0] obs_o [3];
  int         stray;

  pdm_decimator #(.OUTPUT_WIDTH(8), .LOG2_DECIM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .pdm_in       (pdm_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic en, input logic b);
    clk_en = en;
    pdm_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One strobe then three idle cycles; records the outputs after each idle edge.
  task automatic send_bit(input logic b);
    cyc(1'b1, b);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, b);
      obs_v[i] = sample_valid;
      obs_o[i] = sample_out;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    clk_en       = 1'b0;
    pdm_in       = 1'b0;
    sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    vectors++;
    if (sample_out !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_out: got %0d want 0", sample_out);
    end
    vectors++;
    if (sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", sample_valid);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    do_reset();
  endtask

  task automatic test_ones();
    logic [7:0] exp_o [4];
    exp_o = '{8'd136, 8'd255, 8'd255, 8'd255};
    do_reset();
    sample_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      stray = 0;
      for (int s = 0; s < 15; s++) begin
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) if (obs_v[i] !== 1'b0) stray++;
      end
      vectors++;
      if (stray !== 0) begin
        miscompares++;
        $display("FAIL ones_early_valid f%0d: got %0d pulses want 0", f, stray);
      end
      send_bit(1'b1);
      vectors++;
      if (obs_v[0] !== 1'b0 || obs_v[1] !== 1'b1 || obs_v[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL ones_valid_timing f%0d: got %b%b%b want 010",
                 f, obs_v[0], obs_v[1], obs_v[2]);
      end
      vectors++;
      if (obs_o[1] !== exp_o[f]) begin
        miscompares++;
        $display("FAIL ones_sample f%0d: got %0d want %0d", f, obs_o[1], exp_o[f]);
      end
    end
  endtask

  task automatic test_zeros();
    do_reset();
    sample_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 16; s++) send_bit(1'b0);
      vectors++;
      if (obs_v[1] !== 1'b1 || obs_o[1] !== 8'd0) begin
        miscompares++;
        $display("FAIL zeros_sample f%0d: got v=%b %0d want v=1 0", f, obs_v[1], obs_o[1]);
      end
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL zeros_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    sample_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 16; s++) send_bit((s % 2) == 0);
      if (f == 0) begin
        vectors++;
        if (obs_v[1] !== 1'b1 || obs_o[1] !== 8'd72) begin
          miscompares++;
          $display("FAIL alt_first: got v=%b %0d want v=1 72", obs_v[1], obs_o[1]);
        end
      end else if (f >= 2) begin
        vectors++;
        if (obs_v[1] !== 1'b1 || obs_o[1] !== 8'd128) begin
          miscompares++;
          $display("FAIL alt_settled f%0d: got v=%b %0d want v=1 128", f, obs_v[1], obs_o[1]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    sample_ready = 1'b0;
    for (int s = 0; s < 16; s++) send_bit(1'b1);
    vectors++;
    if (obs_v[1] !== 1'b1 || obs_o[1] !== 8'd136 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_first: got v=%b %0d ovr=%b want v=1 136 ovr=0",
               obs_v[1], obs_o[1], overrun);
    end
    for (int s = 0; s < 15; s++) send_bit(1'b1);
    vectors++;
    if (sample_valid !== 1'b1 || sample_out !== 8'd136) begin
      miscompares++;
      $display("FAIL ovr_hold: got v=%b %0d want v=1 136", sample_valid, sample_out);
    end
    send_bit(1'b1);
    vectors++;
    if (obs_o[1] !== 8'd255 || sample_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_overwrite: got %0d v=%b ovr=%b want 255 v=1 ovr=1",
               obs_o[1], sample_valid, overrun);
    end
    sample_ready = 1'b1;
    cyc(1'b0, 1'b1);
    sample_ready = 1'b0;
    vectors++;
    if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_accept: got v=%b ovr=%b want v=0 ovr=1", sample_valid, overrun);
    end
  endtask

  // Continues from test_overrun: overrun is set and sample_out holds 255.
  task automatic test_reset_midframe();
    sample_ready = 1'b1;
    for (int s = 0; s < 7; s++) send_bit(1'b1);
    rst = 1'b0;
    #1;
    vectors++;
    if (sample_out !== 8'd0 || sample_valid !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got %0d v=%b ovr=%b want 0 0 0",
               sample_out, sample_valid, overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stray = 0;
    for (int s = 0; s < 15; s++) begin
      send_bit(1'b1);
      for (int i = 0; i < 3; i++) if (obs_v[i] !== 1'b0) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL mid_phase: got %0d early pulses want 0", stray);
    end
    send_bit(1'b1);
    vectors++;
    if (obs_v[1] !== 1'b1 || obs_o[1] !== 8'd136) begin
      miscompares++;
      $display("FAIL mid_first: got v=%b %0d want v=1 136", obs_v[1], obs_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    int hit;
    do_reset();
    sample_ready = 1'b0;
    hit = 0;
    for (int c = 1; c <= 40 && hit == 0; c++) begin
      cyc(1'b1, 1'b1);
      if (sample_valid === 1'b1) hit = c;
    end
    vectors++;
    if (hit !== 18) begin
      miscompares++;
      $display("FAIL b2b_latency: got cycle %0d want 18", hit);
    end
    for (int c = 0; c < 15; c++) cyc(1'b1, 1'b1);
    vectors++;
    if (sample_valid !== 1'b1 || sample_out !== 8'd136) begin
      miscompares++;
      $display("FAIL b2b_hold: got v=%b %0d want v=1 136", sample_valid, sample_out);
    end
    sample_ready = 1'b1;
    cyc(1'b1, 1'b1);
    sample_ready = 1'b0;
    vectors++;
    if (sample_valid !== 1'b1 || sample_out !== 8'd255 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_same_edge: got v=%b %0d ovr=%b want v=1 255 ovr=0",
               sample_valid, sample_out, overrun);
    end
    sample_ready = 1'b1;
    cyc(1'b1, 1'b1);
    sample_ready = 1'b0;
    vectors++;
    if (sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got v=%b want 0", sample_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ones();
    test_zeros();
    test_alternating();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
